// File: rtl/exint_ctrl.sv
// External interrupt controller: synchronises async IRQ lines, latches enabled
// rising edges as pending, and issues one non-nesting trap request at a time.
module exint_ctrl #(
  parameter int IRQ_NUM     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [IRQ_NUM-1:0]         irq_i,
  input  logic                       en_we_i,
  input  logic [IRQ_NUM-1:0]         en_wdata_i,
  output logic [IRQ_NUM-1:0]         en_o,
  output logic [IRQ_NUM-1:0]         pend_o,
  output logic                       ex_trap_o,
  output logic [$clog2(IRQ_NUM)-1:0] trap_id_o,
  input  logic                       trap_ack_i,
  input  logic                       trap_done_i,
  output logic                       busy_o
);

  localparam int ID_W = $clog2(IRQ_NUM);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  logic [IRQ_NUM-1:0] sync_reg [SYNC_STAGES];
  logic [IRQ_NUM-1:0] sync_out;
  logic [IRQ_NUM-1:0] sync_d_reg;
  logic [IRQ_NUM-1:0] edge_det;
  logic [IRQ_NUM-1:0] en_reg;
  logic [IRQ_NUM-1:0] pend_reg;
  logic [IRQ_NUM-1:0] pend_next;
  logic [IRQ_NUM-1:0] cand;
  logic [IRQ_NUM-1:0] clr_mask;
  logic [ID_W-1:0]    sel_id;
  logic [ID_W-1:0]    id_reg;
  logic [ID_W-1:0]    id_next;
  state_t             state_reg;
  state_t             state_next;
  logic               ack_clr;
  logic               ex_trap_reg;
  logic               ex_trap_next;
  logic               busy_reg;
  logic               busy_next;

  // sync_d_reg resets to 0, so a line held high through reset yields one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_reg[s] <= '0;
      sync_d_reg <= '0;
    end else begin
      sync_reg[0] <= irq_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_reg[s] <= sync_reg[s-1];
      sync_d_reg <= sync_out;
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign edge_det = sync_out & ~sync_d_reg;
  assign cand     = pend_reg & en_reg;

  always_comb begin
    sel_id = '0;
    for (int k = IRQ_NUM - 1; k >= 0; k--) begin
      if (cand[k]) sel_id = ID_W'(k);
    end
  end

  always_comb begin
    clr_mask = '0;
    if (ack_clr) clr_mask[id_reg] = 1'b1;
    // Set is applied after clear so a coincident new edge survives the ack.
    pend_next = (pend_reg & ~clr_mask) | (edge_det & en_reg);
  end

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    ack_clr    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|cand) begin
          id_next    = sel_id;
          state_next = REQ;
        end
      end
      REQ: begin
        if (trap_ack_i) begin
          ack_clr    = 1'b1;
          state_next = SERV;
        end
      end
      SERV: begin
        if (trap_done_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    ex_trap_next = (state_next == REQ);
    busy_next    = (state_next == SERV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      id_reg      <= '0;
      en_reg      <= '0;
      pend_reg    <= '0;
      ex_trap_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      id_reg      <= id_next;
      pend_reg    <= pend_next;
      ex_trap_reg <= ex_trap_next;
      busy_reg    <= busy_next;
      if (en_we_i) en_reg <= en_wdata_i;
    end
  end

  assign en_o      = en_reg;
  assign pend_o    = pend_reg;
  assign ex_trap_o = ex_trap_reg;
  assign trap_id_o = id_reg;
  assign busy_o    = busy_reg;

endmodule

// File: tb/tb_exint_ctrl.sv
// Directed bench for exint_ctrl: hand-timed scenarios plus a short random soak
// checking request/service exclusivity and ID stability.
module tb_exint_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq = '0;
  logic       en_we = 1'b0;
  logic [7:0] en_wdata = '0;
  logic       ack = 1'b0;
  logic       done = 1'b0;
  logic [7:0] en;
  logic [7:0] pend;
  logic       ex_trap;
  logic [2:0] trap_id;
  logic       busy;

  int n_assert = 0;
  int n_fail = 0;

  exint_ctrl #(.IRQ_NUM(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_i       (irq),
    .en_we_i     (en_we),
    .en_wdata_i  (en_wdata),
    .en_o        (en),
    .pend_o      (pend),
    .ex_trap_o   (ex_trap),
    .trap_id_o   (trap_id),
    .trap_ack_i  (ack),
    .trap_done_i (done),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_en(input logic [7:0] v);
    en_we = 1'b1;
    en_wdata = v;
    tick();
    en_we = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic count_traps(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (ex_trap) cnt++;
    end
  endtask

  initial begin
    int cnt;
    logic prev_trap;
    logic [2:0] prev_id;

    // Reset state
    tick(2);
    chk("rst_en", en, 0);
    chk("rst_pend", pend, 0);
    chk("rst_trap", ex_trap, 0);
    chk("rst_id", trap_id, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // 1: single source, latency and handshake
    write_en(8'h01);
    chk("t1_en", en, 8'h01);
    irq[0] = 1'b1;
    tick(3);
    chk("t1_pend_e2", pend, 8'h01);
    chk("t1_notrap_e2", ex_trap, 0);
    tick();
    chk("t1_trap_e3", ex_trap, 1);
    chk("t1_id", trap_id, 0);
    irq[0] = 1'b0;
    pulse_ack();
    chk("t1_ack_trap", ex_trap, 0);
    chk("t1_ack_busy", busy, 1);
    chk("t1_ack_pend", pend, 8'h00);
    pulse_done();
    chk("t1_done_busy", busy, 0);
    chk("t1_done_trap", ex_trap, 0);

    // 2: priority between two simultaneous sources
    write_en(8'hFF);
    irq = 8'h24;
    tick(3);
    chk("t2_pend", pend, 8'h24);
    tick();
    chk("t2_trap1", ex_trap, 1);
    chk("t2_id1", trap_id, 2);
    pulse_ack();
    chk("t2_pend_after_ack", pend, 8'h20);
    chk("t2_busy", busy, 1);
    pulse_done();
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_trap", ex_trap, 0);
    tick();
    chk("t2_trap2", ex_trap, 1);
    chk("t2_id2", trap_id, 5);
    pulse_ack();
    chk("t2_pend_clear", pend, 8'h00);
    pulse_done();
    irq = '0;
    tick(2);

    // 3: edge on a disabled source is dropped
    write_en(8'h00);
    chk("t3_en", en, 8'h00);
    irq[3] = 1'b1;
    tick(3);
    irq[3] = 1'b0;
    tick(3);
    chk("t3_pend", pend, 8'h00);
    chk("t3_trap", ex_trap, 0);
    write_en(8'h08);
    tick(4);
    chk("t3_late_pend", pend, 8'h00);
    chk("t3_late_trap", ex_trap, 0);

    // 4: new edge coincides with ack of the same id
    write_en(8'h01);
    irq[0] = 1'b1;
    tick();
    irq[0] = 1'b0;
    tick();
    irq[0] = 1'b1;
    tick();
    irq[0] = 1'b0;
    chk("t4_pend", pend, 8'h01);
    tick();
    chk("t4_trap", ex_trap, 1);
    chk("t4_id", trap_id, 0);
    pulse_ack();
    chk("t4_pend_kept", pend, 8'h01);
    chk("t4_busy", busy, 1);
    pulse_done();
    chk("t4_idle", busy, 0);
    tick();
    chk("t4_retrap", ex_trap, 1);
    chk("t4_reid", trap_id, 0);
    pulse_ack();
    chk("t4_pend_clear", pend, 8'h00);
    pulse_done();
    count_traps(6, cnt);
    chk("t4_no_extra", cnt, 0);

    // 5: async reset during a request, line held through release
    write_en(8'h02);
    irq[1] = 1'b1;
    tick(4);
    chk("t5_pre_trap", ex_trap, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_trap", ex_trap, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_pend", pend, 0);
    chk("t5_async_en", en, 0);
    tick(2);
    rst_n = 1'b1;
    tick();
    write_en(8'h02);
    chk("t5_en", en, 8'h02);
    tick();
    chk("t5_pend", pend, 8'h02);
    chk("t5_notrap", ex_trap, 0);
    tick();
    chk("t5_trap", ex_trap, 1);
    chk("t5_id", trap_id, 1);
    pulse_ack();
    chk("t5_busy", busy, 1);
    pulse_done();
    chk("t5_idle", busy, 0);
    count_traps(8, cnt);
    chk("t5_one_trap", cnt, 0);
    irq[1] = 1'b0;
    tick(2);

    // 6: out-of-state strobes are ignored
    pulse_done();
    chk("t6_done_idle_trap", ex_trap, 0);
    chk("t6_done_idle_busy", busy, 0);
    pulse_ack();
    chk("t6_ack_idle_trap", ex_trap, 0);
    chk("t6_ack_idle_busy", busy, 0);
    irq[1] = 1'b1;
    tick(4);
    chk("t6_trap", ex_trap, 1);
    ack = 1'b1;
    done = 1'b1;
    tick();
    ack = 1'b0;
    done = 1'b0;
    chk("t6_ackdone_busy", busy, 1);
    chk("t6_ackdone_trap", ex_trap, 0);
    pulse_ack();
    chk("t6_ack_serv_busy", busy, 1);
    chk("t6_ack_serv_trap", ex_trap, 0);
    chk("t6_ack_serv_id", trap_id, 1);
    pulse_done();
    chk("t6_done_busy", busy, 0);
    irq[1] = 1'b0;
    tick(2);

    // Random soak
    write_en(8'hFF);
    prev_trap = 1'b0;
    prev_id = '0;
    for (int i = 0; i < 100; i++) begin
      irq = 8'($urandom);
      ack = ex_trap & 1'($urandom_range(0, 1));
      done = busy & 1'($urandom_range(0, 1));
      tick();
      chk("soak_excl", {31'b0, ex_trap & busy}, 0);
      if (prev_trap && ex_trap) chk("soak_id_stable", trap_id, prev_id);
      prev_trap = ex_trap;
      prev_id = trap_id;
    end
    irq = '0;
    for (int i = 0; i < 80; i++) begin
      ack = ex_trap;
      done = busy;
      tick();
    end
    ack = 1'b0;
    done = 1'b0;
    tick();
    chk("soak_drain_pend", pend, 0);
    chk("soak_drain_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
